dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arbiter_rr_arbiter2.sv | 48 ++++
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared definitions for the data-memory arbiter: FSM state encoding,
//   default address/data widths and the requester identifiers used by the
//   round-robin picker and the last-grant register.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_VGA = 2'd2
    } state_t;

    // Requester identifiers (one bit: only two requesters exist).
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_VGA = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// rr_arbiter2
//   Two-input round-robin picker with its own last-grant register.
//   pick_id names the requester that should win when arbitration happens in
//   IDLE; on a tie the requester NOT recorded in last_grant wins.
//   Optional feature: macro DMEM_ARB_VGA_PRIO_EN makes every tie go to VGA
//   (the last-grant register is still maintained and exported).
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   req_cpu, req_vga  raw request lines
//   upd_en, upd_id    record upd_id as last grant at the next edge
//   pick_id           winning requester for the current requests
//   last_grant        registered last-granted requester (resets to VGA)
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_cpu,
    input  logic req_vga,
    input  logic upd_en,
    input  logic upd_id,
    output logic pick_id,
    output logic last_grant
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= REQ_VGA;
        end else if (upd_en) begin
            last_grant <= upd_id;
        end
    end

    always_comb begin
        pick_id = REQ_CPU;
        if (req_cpu && req_vga) begin
`ifdef DMEM_ARB_VGA_PRIO_EN
            pick_id = REQ_VGA;
`else
            pick_id = (last_grant == REQ_CPU) ? REQ_VGA : REQ_CPU;
`endif
        end else if (req_vga) begin
            pick_id = REQ_VGA;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Arbitrates a single-port data memory (1-cycle synchronous read) between
//   the processor and the display reader.
//   Optional feature: macro DMEM_ARB_VGA_PRIO_EN (ties always go to VGA).
//
// Handshake: a requester raises x_req with its address (and write data) and
//   holds them stable until it sees x_gnt. x_gnt is high for exactly one
//   cycle; that cycle is the memory access. The request level seen during the
//   grant cycle belongs to the transaction being granted, so a new request
//   from the same requester is considered only after it. Read data comes back
//   on x_rvalid/x_rdata one cycle after the grant; x_rdata holds afterwards.
//
// Ports
//   clk, reset                                 clock, async active-low reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata          processor request
//   cpu_gnt/cpu_stall/cpu_rvalid/cpu_rdata     processor grant, stall, read return
//   vga_req/vga_addr                           display read request
//   vga_gnt/vga_rvalid/vga_rdata               display grant and read return
//   mem_addr/mem_wren/mem_data/mem_q           memory port
//   dbg_state/dbg_last_grant                   FSM state and last grant, for observation
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q,
    output state_t            dbg_state,
    output logic              dbg_last_grant
);

    state_t            state;
    state_t            state_nxt;
    logic              pick_id;
    logic              last_grant;
    logic              rr_upd_en;
    logic              rr_upd_id;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vga_rdata_q;

    assign rr_upd_en = (state != IDLE);
    assign rr_upd_id = (state == GNT_VGA) ? REQ_VGA : REQ_CPU;

    rr_arbiter2 u_rr (
        .clk        (clk),
        .reset      (reset),
        .req_cpu    (cpu_req),
        .req_vga    (vga_req),
        .upd_en     (rr_upd_en),
        .upd_id     (rr_upd_id),
        .pick_id    (pick_id),
        .last_grant (last_grant)
    );

    // Leaving a grant state only looks at the other requester: the granted
    // one's req is still up for the transaction just served. This also
    // bounds the display wait to two cycles behind a continuous CPU stream.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (cpu_req || vga_req) begin
                    state_nxt = (pick_id == REQ_VGA) ? GNT_VGA : GNT_CPU;
                end
            end
            GNT_CPU: state_nxt = vga_req ? GNT_VGA : IDLE;
            GNT_VGA: state_nxt = cpu_req ? GNT_CPU : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM plus read-return pipeline. Clearing the return flags on reset
    // drops any read whose data was still in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cpu_rvalid  <= 1'b0;
            vga_rvalid  <= 1'b0;
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
        end else begin
            state      <= state_nxt;
            cpu_rvalid <= (state == GNT_CPU) && cpu_req && !cpu_we;
            vga_rvalid <= (state == GNT_VGA);
            if (cpu_rvalid) begin
                cpu_rdata_q <= mem_q;
            end
            if (vga_rvalid) begin
                vga_rdata_q <= mem_q;
            end
        end
    end

    // mem_q is only valid in the return cycle, so pass it through then and
    // show the captured copy at all other times.
    assign cpu_rdata = cpu_rvalid ? mem_q : cpu_rdata_q;
    assign vga_rdata = vga_rvalid ? mem_q : vga_rdata_q;

    assign cpu_gnt   = (state == GNT_CPU);
    assign vga_gnt   = (state == GNT_VGA);
    assign cpu_stall = cpu_req && !cpu_gnt;

    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        case (state)
            GNT_CPU: begin
                mem_addr = cpu_addr;
                mem_data = cpu_req ? cpu_wdata : '0;
                mem_wren = cpu_req && cpu_we;
            end
            GNT_VGA: begin
                mem_addr = vga_addr;
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

    assign dbg_state      = state;
    assign dbg_last_grant = last_grant;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a behavioural 4096x32 memory, a
//   reference memory model, per-requester expected-read queues and a
//   negedge monitor that pops and compares on every read return.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt, cpu_stall, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          vga_req = 1'b0;
    logic [AW-1:0] vga_addr = '0;
    logic          vga_gnt, vga_rvalid;
    logic [DW-1:0] vga_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_wren;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_q = '0;
    state_t        dbg_state;
    logic          dbg_last_grant;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_gnt        (cpu_gnt),
        .cpu_stall      (cpu_stall),
        .cpu_rvalid     (cpu_rvalid),
        .cpu_rdata      (cpu_rdata),
        .vga_req        (vga_req),
        .vga_addr       (vga_addr),
        .vga_gnt        (vga_gnt),
        .vga_rvalid     (vga_rvalid),
        .vga_rdata      (vga_rdata),
        .mem_addr       (mem_addr),
        .mem_wren       (mem_wren),
        .mem_data       (mem_data),
        .mem_q          (mem_q),
        .dbg_state      (dbg_state),
        .dbg_last_grant (dbg_last_grant)
    );

    // ---------------- memory environment and reference model ----------------
    logic [DW-1:0] mem     [0:4095];
    logic [DW-1:0] ref_mem [0:4095];

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 32'(i) * 32'h9E37_79B9 + 32'h0000_1234;
            ref_mem[i] = 32'(i) * 32'h9E37_79B9 + 32'h0000_1234;
        end
    end

    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_data;
        mem_q <= mem[mem_addr];
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] cpu_exp_q[$];
    logic [DW-1:0] vga_exp_q[$];
    logic [DW-1:0] cpu_last = '0;
    logic [DW-1:0] vga_last = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops on every read return, checks hold values, grant
    // exclusivity, write gating, idle bus values and stall.
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_gnt",       32'({cpu_gnt, vga_gnt}), 32'd0);
            chk("rst_rvalid",    32'({cpu_rvalid, vga_rvalid}), 32'd0);
            chk("rst_wren",      32'(mem_wren), 32'd0);
            chk("rst_mem_addr",  32'(mem_addr), 32'd0);
            chk("rst_mem_data",  mem_data, 32'd0);
            chk("rst_cpu_rdata", cpu_rdata, 32'd0);
            chk("rst_vga_rdata", vga_rdata, 32'd0);
            chk("rst_state",     32'(dbg_state), 32'(IDLE));
            cpu_exp_q.delete();
            vga_exp_q.delete();
            cpu_last = '0;
            vga_last = '0;
        end else begin
            if (cpu_gnt || vga_gnt) chk("one_gnt", 32'(cpu_gnt && vga_gnt), 32'd0);
            if (mem_wren) chk("wren_only_cpu", 32'(cpu_gnt), 32'd1);
            if (!cpu_gnt && !vga_gnt) begin
                chk("idle_mem_addr", 32'(mem_addr), 32'd0);
                chk("idle_mem_data", mem_data, 32'd0);
            end
            chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !cpu_gnt));
            if (cpu_rvalid) begin
                if (cpu_exp_q.size() == 0) begin
                    chk("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'd0);
                    cpu_last = cpu_rdata;
                end else begin
                    cpu_last = cpu_exp_q.pop_front();
                    chk("cpu_rdata", cpu_rdata, cpu_last);
                end
            end else begin
                chk("cpu_rdata_hold", cpu_rdata, cpu_last);
            end
            if (vga_rvalid) begin
                if (vga_exp_q.size() == 0) begin
                    chk("vga_rvalid_unexpected", 32'(vga_rvalid), 32'd0);
                    vga_last = vga_rdata;
                end else begin
                    vga_last = vga_exp_q.pop_front();
                    chk("vga_rdata", vga_rdata, vga_last);
                end
            end else begin
                chk("vga_rdata_hold", vga_rdata, vga_last);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // wait_c = cycles from request to grant (1 = granted on the next edge).
    task automatic cpu_txn(input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, output int wait_c);
        bit got;
        got = 1'b0;
        wait_c = 0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        while (!got && wait_c <= 20) begin
            @(negedge clk);
            if (cpu_gnt) got = 1'b1;
            else wait_c++;
        end
        if (!got) begin
            chk("cpu_gnt_timeout", 32'(cpu_gnt), 32'd1);
        end else begin
            chk("cpu_mem_addr", 32'(mem_addr), 32'(addr));
            chk("cpu_mem_wren", 32'(mem_wren), 32'(we));
            if (we) begin
                chk("cpu_mem_data", mem_data, wdata);
                ref_mem[addr] = wdata;
            end else begin
                cpu_exp_q.push_back(ref_mem[addr]);
            end
        end
        @(posedge clk); #1;
        // Junk on we/wdata while idle must have no effect.
        cpu_req = 1'b0; cpu_we = 1'b1; cpu_wdata = 32'hBAD0_BAD0;
        if (got) begin
            @(negedge clk);
            chk("cpu_gnt_1cyc", 32'(cpu_gnt), 32'd0);
            chk("cpu_rvalid_after", 32'(cpu_rvalid), 32'(!we));
        end
    endtask

    task automatic vga_txn(input logic [AW-1:0] addr, output int wait_c);
        bit got;
        got = 1'b0;
        wait_c = 0;
        @(posedge clk); #1;
        vga_req = 1'b1; vga_addr = addr;
        while (!got && wait_c <= 20) begin
            @(negedge clk);
            if (vga_gnt) got = 1'b1;
            else wait_c++;
        end
        if (!got) begin
            chk("vga_gnt_timeout", 32'(vga_gnt), 32'd1);
        end else begin
            chk("vga_mem_addr", 32'(mem_addr), 32'(addr));
            chk("vga_mem_wren", 32'(mem_wren), 32'd0);
            chk("vga_mem_data", mem_data, 32'd0);
            vga_exp_q.push_back(ref_mem[addr]);
        end
        @(posedge clk); #1;
        vga_req = 1'b0;
        if (got) begin
            @(negedge clk);
            chk("vga_gnt_1cyc", 32'(vga_gnt), 32'd0);
            chk("vga_rvalid_after", 32'(vga_rvalid), 32'd1);
        end
    endtask

    // CPU read request held high for at least n cycles, ending on a grant.
    task automatic cpu_stream(input logic [AW-1:0] addr, input int n);
        int  c;
        int  grants;
        bit  last_g;
        c = 0; grants = 0; last_g = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
        while ((c < n || !last_g) && c < n + 10) begin
            @(negedge clk);
            last_g = cpu_gnt;
            if (cpu_gnt) begin
                grants++;
                cpu_exp_q.push_back(ref_mem[addr]);
            end
            c++;
        end
        chk("stream_ends_on_gnt", 32'(last_g), 32'd1);
        chk("stream_has_grants", 32'(grants >= n / 4), 32'd1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    int cw, vw;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          rwe;

    initial begin
        // reset phase: monitor checks outputs while reset is low
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;

        // Simultaneous requests right after reset (last grant = VGA)
        fork
            cpu_txn(1'b0, 12'h030, 32'h0, cw);
            vga_txn(12'h040, vw);
        join
`ifdef DMEM_ARB_VGA_PRIO_EN
        chk("tie_cpu_wait", 32'(cw), 32'd2);
        chk("tie_vga_wait", 32'(vw), 32'd1);
`else
        chk("tie_cpu_wait", 32'(cw), 32'd1);
        chk("tie_vga_wait", 32'(vw), 32'd2);
`endif

        // Write then read back the same word
        cpu_txn(1'b1, 12'h010, 32'hDEAD_BEEF, cw);
        chk("wr_wait", 32'(cw), 32'd1);
        cpu_txn(1'b0, 12'h010, 32'h0, cw);
        chk("rd_wait", 32'(cw), 32'd1);
        chk("rd_deadbeef", cpu_rdata, 32'hDEAD_BEEF);

        // Continuous CPU requests with VGA pulses
        fork
            cpu_stream(12'h020, 40);
            begin
                for (int k = 0; k < 6; k++) begin
                    vga_txn(12'(12'h100 + k), vw);
                    chk("stream_vga_wait_le2", 32'(vw <= 2), 32'd1);
                    @(posedge clk);
                end
            end
        join
        repeat (2) @(negedge clk);

        // Reset during a VGA grant
        @(posedge clk); #1;
        vga_req = 1'b1; vga_addr = 12'h055;
        @(negedge clk);
        chk("t4_wait_cycle", 32'(vga_gnt), 32'd0);
        @(negedge clk);
        chk("t4_gnt", 32'(vga_gnt), 32'd1);
        chk("t4_mem_addr", 32'(mem_addr), 32'h055);
        #1 reset = 1'b0;
        #1;
        chk("t4_async_gnt",   32'(vga_gnt), 32'd0);
        chk("t4_async_addr",  32'(mem_addr), 32'd0);
        chk("t4_async_state", 32'(dbg_state), 32'(IDLE));
        chk("t4_async_rv",    32'(vga_rvalid), 32'd0);
        vga_req = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_no_rvalid", 32'(vga_rvalid), 32'd0);
        end
        vga_txn(12'h056, vw);
        chk("t4_resume_wait", 32'(vw), 32'd1);

        // Random request patterns against the reference memory
        for (int i = 0; i < 100; i++) begin
            fork
                begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    if ($urandom_range(0, 3) != 0) begin
                        ra  = 12'($urandom_range(0, 15)) | ((i % 2 == 1) ? 12'hFF0 : 12'h000);
                        rd  = $urandom;
                        rwe = 1'($urandom_range(0, 1));
                        cpu_txn(rwe, ra, rd, cw);
                    end
                end
                begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    if ($urandom_range(0, 3) != 0) begin
                        vga_txn(12'($urandom_range(0, 15)) | ((i % 2 == 1) ? 12'hFF0 : 12'h000), vw);
                        chk("rand_vga_wait_le2", 32'(vw <= 2), 32'd1);
                    end
                end
            join
        end

        repeat (4) @(negedge clk);
        chk("cpu_q_empty", 32'(cpu_exp_q.size()), 32'd0);
        chk("vga_q_empty", 32'(vga_exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
